// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions: transfer-type and transfer-size encodings,
// the byte-strobe decoder used by the address phase, and the byte-lane
// merge used by the RAM when a write and a read hit the same word.
// ---------------------------------------------------------------------------
package ahb_pkg;

  // HTRANS encodings; bit 1 alone distinguishes a real transfer (NONSEQ/SEQ)
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // HSIZE encodings; anything wider than a word is handled as a word
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Byte-lane strobes for a transfer; misaligned low address bits are ignored
  function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        if (addr_lo[1]) begin
          strb = 4'b1100;
        end else begin
          strb = 4'b0011;
        end
      end
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // New bytes on strobed lanes, old bytes elsewhere
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_sp_bwe.sv
// ---------------------------------------------------------------------------
// sram_sp_bwe
// 32-bit word RAM with four byte-write enables and a registered read port.
// Read and write use separate addresses so that one write and one read can
// happen on the same edge; a read of the word being written returns the
// merged (write-first) value.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   async active-low reset (read register only, not contents)
//   re     in   capture read data at this edge
//   raddr  in   read word index
//   we     in   per-byte write enables
//   waddr  in   write word index
//   wdata  in   write data, little-endian lanes
//   rdata  out  registered read data, holds when re=0
// ---------------------------------------------------------------------------
module sram_sp_bwe
  import ahb_pkg::*;
#(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Storage; deliberately not reset so images can be loaded by backdoor
  logic [31:0] mem [0:WORDS-1];

  logic [31:0] rd_word_s;

  // Read word with same-edge write forwarded onto the strobed lanes
  always_comb begin
    rd_word_s = mem[raddr];
    if ((we != 4'h0) && (waddr == raddr)) begin
      rd_word_s = merge_lanes(mem[raddr], wdata, we);
    end else begin
      rd_word_s = mem[raddr];
    end
  end

  // Byte-lane write port; a plain always block so benches may also assign mem
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read port; holds its last value between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0000_0000;
    end else if (re) begin
      rdata <= rd_word_s;
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
// Zero-wait-state AHB-Lite slave in front of a byte-writable word RAM of
// MEMSIZE bytes located at a runtime base address. Addresses outside the
// window wrap modulo MEMSIZE. The RAM array is reachable as u_ram.mem.
//
// Ports:
//   hclk        in   bus clock
//   hreset_n    in   async active-low reset
//   hsel        in   slave select (address phase)
//   base_addr   in   byte address of RAM word 0, static after reset
//   htrans      in   transfer type
//   haddr       in   byte address (address phase)
//   hsize       in   transfer size, >2 handled as word
//   hwdata      in   write data (data phase)
//   hwrite      in   write/read (address phase)
//   hready_in   in   global HREADY
//   hrdata      out  read data (data phase), holds otherwise
//   hresp       out  always OKAY
//   hready_out  out  always ready
// ---------------------------------------------------------------------------
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int MEMSIZE = 1024
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [31:0] base_addr,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hwrite,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hresp,
  output logic        hready_out
);

  localparam int WORDS = MEMSIZE / 4;
  // A one-word RAM still gets a 1-bit index, masked to zero below
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AW-1:0] WMASK = AW'(WORDS - 1);

  logic          accept_s;
  logic [AW-1:0] word_idx_s;
  logic [3:0]    strb_s;
  logic [3:0]    ram_we_s;

  // Data-phase state, probed hierarchically by benches
  logic          hbus_ena_d;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;

  // Address-phase decode: accept, wrapped word index, lane strobes
  always_comb begin
    // htrans[1] is set exactly for NONSEQ and SEQ
    accept_s   = hsel & hready_in & htrans[1];
    word_idx_s = AW'((haddr - base_addr) >> 2) & WMASK;
    strb_s     = byte_strobe(hsize, haddr[1:0]);
  end

  // Capture address-phase information for the following data phase
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      hbus_ena_d <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'h0;
    end else if (accept_s) begin
      hbus_ena_d <= 1'b1;
      mem_addr   <= word_idx_s;
      mem_wstrb  <= hwrite ? strb_s : 4'h0;
    end else begin
      hbus_ena_d <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'h0;
    end
  end

  // Write enables only during an active data phase
  always_comb begin
    if (hbus_ena_d) begin
      ram_we_s = mem_wstrb;
    end else begin
      ram_we_s = 4'h0;
    end
  end

  // Response outputs are constant but kept registered with defined reset
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      hresp      <= 1'b0;
      hready_out <= 1'b1;
    end else begin
      hresp      <= 1'b0;
      hready_out <= 1'b1;
    end
  end

  // Read address is presented in the address phase so data lands in the data phase
  sram_sp_bwe #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (hclk),
    .rst_n (hreset_n),
    .re    (accept_s & ~hwrite),
    .raddr (word_idx_s),
    .we    (ram_we_s),
    .waddr (mem_addr),
    .wdata (hwdata),
    .rdata (hrdata)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
// Directed and randomized bench for ahb_sram_slave with a byte-array
// reference model of the memory.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int          MEMSIZE = 1024;
  localparam int          WORDS   = MEMSIZE / 4;
  localparam logic [31:0] BASE    = 32'h2000_0000;

  logic        hclk;
  logic        hreset_n;
  logic        hsel;
  logic [31:0] base_addr;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hwrite;
  logic        hready_in;
  logic [31:0] hrdata;
  logic        hresp;
  logic        hready_out;

  ahb_sram_slave #(.MEMSIZE(MEMSIZE)) dut (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .hsel       (hsel),
    .base_addr  (base_addr),
    .htrans     (htrans),
    .haddr      (haddr),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hwrite     (hwrite),
    .hready_in  (hready_in),
    .hrdata     (hrdata),
    .hresp      (hresp),
    .hready_out (hready_out)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: plain byte array indexed by window offset
  logic [7:0]  ref_mem [0:MEMSIZE-1];
  logic        pend_wr;
  logic [31:0] pend_addr;
  logic [2:0]  pend_size;
  logic [31:0] pend_data;
  logic [31:0] exp_rd;

  // Console sink: prints the low byte of writes to word 0 while enabled
  logic console_on = 1'b0;
  int   console_cnt = 0;
  always @(negedge hclk) begin
    if (console_on && dut.hbus_ena_d && (dut.mem_wstrb != 4'h0) && (dut.mem_addr == '0)) begin
      $display("console: %c", hwdata[7:0]);
      console_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) % 32'(MEMSIZE);
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int w;
    w = word_of(a);
    return {ref_mem[w*4+3], ref_mem[w*4+2], ref_mem[w*4+1], ref_mem[w*4]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] size, input logic [31:0] d);
    int w, n, lo;
    w  = word_of(a);
    n  = (size == 3'd0) ? 1 : ((size == 3'd1) ? 2 : 4);
    lo = int'(a[1:0]);
    lo = lo - (lo % n);
    for (int k = 0; k < n; k++) begin
      ref_mem[w*4 + lo + k] = d[8*(lo+k) +: 8];
    end
  endtask

  task automatic backdoor(input int w, input logic [31:0] v);
    dut.u_ram.mem[w] = v;
    for (int k = 0; k < 4; k++) ref_mem[w*4+k] = v[8*k +: 8];
  endtask

  // One bus cycle: new address phase plus data phase of the previous transfer
  task automatic step(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                      input logic [2:0] size, input logic wr, input logic rdy,
                      input logic [31:0] wdata);
    logic acc;
    hwdata    = pend_data;
    hsel      = sel;
    htrans    = trans;
    haddr     = addr;
    hsize     = size;
    hwrite    = wr;
    hready_in = rdy;
    acc       = sel && rdy && trans[1];
    @(posedge hclk);
    #1;
    if (pend_wr) model_write(pend_addr, pend_size, pend_data);
    if (acc && !wr) exp_rd = model_word(addr);
    pend_wr   = acc && wr;
    pend_addr = addr;
    pend_size = size;
    pend_data = (acc && wr) ? wdata : $urandom;
    check("hrdata", hrdata, exp_rd);
    check("hbus_ena_d", 32'(dut.hbus_ena_d), 32'(acc));
    check("wstrb_active", 32'(dut.mem_wstrb != 4'h0), 32'(acc && wr));
    check("hready_out", 32'(hready_out), 32'h1);
    check("hresp", 32'(hresp), 32'h0);
  endtask

  task automatic idle();
    step(1'b0, HTRANS_IDLE, BASE, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    hreset_n  = 1'b0;
    hsel      = 1'b0;
    base_addr = BASE;
    htrans    = HTRANS_IDLE;
    haddr     = 32'h0;
    hsize     = HSIZE_WORD;
    hwdata    = 32'h0;
    hwrite    = 1'b0;
    hready_in = 1'b1;
    pend_wr   = 1'b0;
    pend_addr = 32'h0;
    pend_size = 3'd0;
    pend_data = 32'h0;
    exp_rd    = 32'h0;
    #1;
    for (int i = 0; i < WORDS; i++) backdoor(i, 32'h0);
    repeat (2) @(posedge hclk);
    #1;
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_hresp", 32'(hresp), 32'h0);
    check("rst_hready_out", 32'(hready_out), 32'h1);
    check("rst_hbus_ena_d", 32'(dut.hbus_ena_d), 32'h0);
    check("rst_mem_wstrb", 32'(dut.mem_wstrb), 32'h0);
    check("rst_mem_addr", 32'(dut.mem_addr), 32'h0);
    hreset_n = 1'b1;

    // Word write then read
    step(1'b1, HTRANS_NONSEQ, BASE, HSIZE_WORD, 1'b1, 1'b1, 32'hDEAD_BEEF);
    idle();
    step(1'b1, HTRANS_NONSEQ, BASE, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
    check("word_rd", hrdata, 32'hDEAD_BEEF);
    idle();

    // Byte and half writes into a preloaded word
    backdoor(1, 32'h1122_3344);
    step(1'b1, HTRANS_NONSEQ, BASE + 32'h5, HSIZE_BYTE, 1'b1, 1'b1, 32'h0000_AA00);
    idle();
    step(1'b1, HTRANS_NONSEQ, BASE + 32'h4, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
    check("byte_rd", hrdata, 32'h1122_AA44);
    step(1'b1, HTRANS_NONSEQ, BASE + 32'h6, HSIZE_HALF, 1'b1, 1'b1, 32'hBEEF_0000);
    step(1'b1, HTRANS_SEQ, BASE + 32'h4, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
    check("half_raw_rd", hrdata, 32'hBEEF_AA44);
    idle();

    // Write immediately followed by read of the same word
    step(1'b1, HTRANS_NONSEQ, BASE + 32'h8, HSIZE_WORD, 1'b1, 1'b1, 32'hCAFE_F00D);
    step(1'b1, HTRANS_SEQ, BASE + 32'h8, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
    check("raw_rd", hrdata, 32'hCAFE_F00D);
    idle();

    // Backdoor load and wrapped access
    backdoor(3, 32'h1234_5678);
    step(1'b1, HTRANS_NONSEQ, BASE + 32'hC, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
    check("bd_rd", hrdata, 32'h1234_5678);
    step(1'b1, HTRANS_NONSEQ, BASE + 32'(MEMSIZE) + 32'hC, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
    check("wrap_rd", hrdata, 32'h1234_5678);
    idle();

    // Non-transfers must not write
    step(1'b1, HTRANS_IDLE, BASE + 32'h10, HSIZE_WORD, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, HTRANS_BUSY, BASE + 32'h10, HSIZE_WORD, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, HTRANS_NONSEQ, BASE + 32'h10, HSIZE_WORD, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, HTRANS_NONSEQ, BASE + 32'h10, HSIZE_WORD, 1'b1, 1'b0, 32'hFFFF_FFFF);
    idle();
    step(1'b1, HTRANS_NONSEQ, BASE + 32'h10, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
    check("noxfer_rd", hrdata, 32'h0);
    idle();

    // Console write
    console_on = 1'b1;
    step(1'b1, HTRANS_NONSEQ, BASE, HSIZE_BYTE, 1'b1, 1'b1, 32'h0000_0041);
    check("con_mem_addr", 32'(dut.mem_addr), 32'h0);
    check("con_wstrb", 32'(dut.mem_wstrb), 32'h1);
    idle();
    idle();
    console_on = 1'b0;
    check("console_cnt", 32'(console_cnt), 32'h1);

    // Reset during a write data phase drops the write
    step(1'b1, HTRANS_NONSEQ, BASE + 32'h14, HSIZE_WORD, 1'b1, 1'b1, 32'h55AA_55AA);
    hwdata   = pend_data;
    hsel     = 1'b0;
    htrans   = HTRANS_IDLE;
    hreset_n = 1'b0;
    #1;
    check("rstmid_ena", 32'(dut.hbus_ena_d), 32'h0);
    check("rstmid_wstrb", 32'(dut.mem_wstrb), 32'h0);
    check("rstmid_hrdata", hrdata, 32'h0);
    @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    pend_wr  = 1'b0;
    exp_rd   = 32'h0;
    step(1'b1, HTRANS_NONSEQ, BASE + 32'h14, HSIZE_WORD, 1'b0, 1'b1, 32'h0);
    check("rstmid_rd", hrdata, 32'h0);
    idle();

    // Randomized traffic, biased to a few words for hazards and to wrap
    for (int n = 0; n < 500; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 1) == 0) begin
        a = BASE + 32'($urandom_range(0, 15));
      end else begin
        a = BASE + 32'($urandom_range(0, 3 * MEMSIZE)) - 32'(MEMSIZE);
      end
      step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), a,
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) != 0), $urandom);
    end
    idle();
    idle();

    // Final contents against the model
    for (int i = 0; i < WORDS; i++) begin
      check("final_mem", dut.u_ram.mem[i],
            {ref_mem[i*4+3], ref_mem[i*4+2], ref_mem[i*4+1], ref_mem[i*4]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
